// File: rtl/mix_columns_engine.sv
// AES (Inv)MixColumns engine, COLS_PER_CYCLE columns per cycle; INV_MIX_EN adds the inverse datapath.
// Latency: 4/COLS_PER_CYCLE cycles from accept to out_valid.
// Backpressure: result held in DONE until out_ready; handoff and new accept may share a cycle.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int STEP_I = COLS_PER_CYCLE;
  localparam int LAST_I = 4 - COLS_PER_CYCLE;
  localparam logic [1:0] STEP = STEP_I[1:0];
  localparam logic [1:0] LAST = LAST_I[1:0];

  // Coefficient for byte j of output row r is ROW[(j - r) mod 4].
  localparam logic [3:0][3:0] FWD_ROW = {4'd1, 4'd1, 4'd3, 4'd2};
  localparam logic [3:0][3:0] INV_ROW = {4'd9, 4'd13, 4'd11, 4'd14};

  state_t          state, state_nxt;
  logic [1:0]      col_idx;
  logic [127:0]    data_q;
  logic            mode_q;
  logic            accept;
  logic [127:0]    result_nxt;
  logic [3:0][3:0] coef_row;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul = ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic [3:0][3:0] coef);
    logic [7:0] acc;
    mix_col = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gmul(w[8*j +: 8], coef[2'(j - r)]);
      end
      mix_col[8*r +: 8] = acc;
    end
  endfunction

`ifdef INV_MIX_EN
  assign coef_row = mode_q ? INV_ROW : FWD_ROW;
`else
  logic unused_mode;
  assign coef_row    = FWD_ROW;
  assign unused_mode = mode_q;
`endif

  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  // Columns not in the current group keep their previously written value.
  always_comb begin
    logic [1:0] idx;
    result_nxt = out_data;
    idx        = col_idx;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      idx = col_idx + 2'(g);
      result_nxt[{idx, 5'd0} +: 32] = mix_col(data_q[{idx, 5'd0} +: 32], coef_row);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (col_idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col_idx  <= 2'd0;
      data_q   <= '0;
      mode_q   <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q  <= in_data;
        mode_q  <= in_mode;
        col_idx <= 2'd0;
      end else if (state == BUSY) begin
        out_data <= result_nxt;
        col_idx  <= col_idx + STEP;
      end
    end
  end

endmodule
